mmio_acc_host_ctrl: RTL

//  Host-side initiator for the MMIO accelerator command/response interface.

---
 rtl/mmio_acc_host_ctrl_if.sv | 50 +++++
 rtl/mmio_acc_host_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mmio_acc_host_ctrl_if.sv
// Bus bundles for the MMIO accelerator host controller.
// mmio_bus_if: CPU register access. master = CPU, slave = controller.
// acc_cmd_if: accelerator command/response. master = controller, slave = accelerator.

interface mmio_bus_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

interface acc_cmd_if #(
    parameter int CFG_REG_WIDTH = 32,
    parameter int NUM_CFG_REGS  = 3
);
    logic                                  acc_input_valid;
    logic                                  acc_input_ready;
    logic [CFG_REG_WIDTH-1:0]              acc_funct;
    logic [NUM_CFG_REGS*CFG_REG_WIDTH-1:0] acc_cfg;
    logic                                  acc_output_valid;
    logic                                  acc_output_ready;
    logic [63:0]                           acc_data_out;
    logic                                  acc_busy;

    modport master (
        output acc_input_valid, acc_funct, acc_cfg, acc_output_ready,
        input  acc_input_ready, acc_output_valid, acc_data_out, acc_busy
    );

    modport slave (
        input  acc_input_valid, acc_funct, acc_cfg, acc_output_ready,
        output acc_input_ready, acc_output_valid, acc_data_out, acc_busy
    );
endinterface

// File: rtl/mmio_acc_host_ctrl.sv
// Host-side initiator: MMIO register file (CTRL/STATUS/FUNCT/LATENCY/RESULT/CFG) driving one accelerator command per START.
// Latency: MMIO response one cycle after acceptance; register writes visible the next cycle.
// Backpressure: MMIO never stalls (req_ready=1 out of reset); accelerator command held until accepted, aborted on timeout.
// Ports: clock, reset (async active-low), mmio (slave side of mmio_bus_if), acc (master side of acc_cmd_if).

module mmio_acc_host_ctrl #(
    parameter int ADDR_WIDTH     = 8,
    parameter int CFG_REG_WIDTH  = 32,
    parameter int NUM_CFG_REGS   = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clock,
    input  logic       reset,
    mmio_bus_if.slave  mmio,
    acc_cmd_if.master  acc
);
    localparam int W  = CFG_REG_WIDTH;
    localparam int WA = ADDR_WIDTH - 2;

    // Word indices (byte address >> 2)
    localparam logic [WA-1:0] A_CTRL   = WA'(0);
    localparam logic [WA-1:0] A_STATUS = WA'(1);
    localparam logic [WA-1:0] A_FUNCT  = WA'(2);
    localparam logic [WA-1:0] A_LAT    = WA'(3);
    localparam logic [WA-1:0] A_RLO    = WA'(4);
    localparam logic [WA-1:0] A_RHI    = WA'(5);
    localparam logic [WA-1:0] A_CFG0   = WA'(8);
    localparam logic [W-1:0]  TO_VAL   = W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t         state;
    logic [W-1:0]   funct;
    logic [W-1:0]   cfg_q [NUM_CFG_REGS];
    logic [63:0]    result;
    logic [W-1:0]   latency;
    logic           done;
    logic           timeout;
    logic           start_dropped;
    logic           req_ready;
    logic           resp_valid;
    logic [W-1:0]   resp_rdata;
    logic           input_valid;
    logic           output_ready;

    logic                    busy;
    logic                    accept;
    logic                    wr_en;
    logic [WA-1:0]           word;
    logic [WA-1:0]           cfg_off;
    logic                    cfg_hit;
    logic [NUM_CFG_REGS-1:0] cfg_sel;
    logic                    ctrl_wr;
    logic                    start_req;
    logic                    clr_req;
    logic [W-1:0]            rd_mux;

    assign busy      = (state != S_IDLE);
    assign accept    = mmio.req_valid && req_ready;
    assign wr_en     = accept && mmio.req_write;
    assign word      = mmio.req_addr[ADDR_WIDTH-1:2];
    assign cfg_off   = word - A_CFG0;
    assign cfg_hit   = (word >= A_CFG0) && (cfg_off < WA'(NUM_CFG_REGS));
    assign ctrl_wr   = wr_en && (word == A_CTRL);
    assign start_req = ctrl_wr && mmio.req_wdata[0];
    assign clr_req   = ctrl_wr && mmio.req_wdata[1];

    always_comb begin
        for (int i = 0; i < NUM_CFG_REGS; i++) begin
            cfg_sel[i] = cfg_hit && (cfg_off == WA'(i));
        end
    end

    always_comb begin
        rd_mux = '0;
        case (word)
            A_STATUS: rd_mux = W'({acc.acc_busy, start_dropped, timeout, done, busy});
            A_FUNCT:  rd_mux = funct;
            A_LAT:    rd_mux = latency;
            A_RLO:    rd_mux = W'(result[31:0]);
            A_RHI:    rd_mux = W'(result[63:32]);
            default: begin
                for (int i = 0; i < NUM_CFG_REGS; i++) begin
                    if (cfg_sel[i]) rd_mux = cfg_q[i];
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            funct         <= '0;
            for (int i = 0; i < NUM_CFG_REGS; i++) cfg_q[i] <= '0;
            result        <= '0;
            latency       <= '0;
            done          <= 1'b0;
            timeout       <= 1'b0;
            start_dropped <= 1'b0;
            req_ready     <= 1'b0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            input_valid   <= 1'b0;
            output_ready  <= 1'b0;
        end else begin
            req_ready  <= 1'b1;
            resp_valid <= accept;
            resp_rdata <= (accept && !mmio.req_write) ? rd_mux : '0;

            // Configuration is frozen while a command is in flight.
            if (wr_en && !busy && (word == A_FUNCT)) funct <= mmio.req_wdata;
            for (int i = 0; i < NUM_CFG_REGS; i++) begin
                if (wr_en && !busy && cfg_sel[i]) cfg_q[i] <= mmio.req_wdata;
            end

            // Clear is applied before any same-cycle start or FSM event.
            if (clr_req) begin
                done          <= 1'b0;
                timeout       <= 1'b0;
                start_dropped <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start_req) begin
                        state       <= S_ISSUE;
                        input_valid <= 1'b1;
                        done        <= 1'b0;
                        timeout     <= 1'b0;
                        latency     <= W'(1);
                    end
                end
                S_ISSUE: begin
                    if (start_req) start_dropped <= 1'b1;
                    if (latency == TO_VAL) begin
                        timeout     <= 1'b1;
                        input_valid <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        if (latency != '1) latency <= latency + 1'b1;
                        if (acc.acc_input_ready) begin
                            input_valid  <= 1'b0;
                            output_ready <= 1'b1;
                            state        <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (start_req) start_dropped <= 1'b1;
                    // A result arriving on the timeout cycle still counts as success.
                    if (acc.acc_output_valid) begin
                        result       <= acc.acc_data_out;
                        done         <= 1'b1;
                        output_ready <= 1'b0;
                        state        <= S_IDLE;
                    end else if (latency == TO_VAL) begin
                        timeout      <= 1'b1;
                        output_ready <= 1'b0;
                        state        <= S_IDLE;
                    end else if (latency != '1) begin
                        latency <= latency + 1'b1;
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    input_valid  <= 1'b0;
                    output_ready <= 1'b0;
                end
            endcase
        end
    end

    assign mmio.req_ready   = req_ready;
    assign mmio.resp_valid  = resp_valid;
    assign mmio.resp_rdata  = resp_rdata;
    assign acc.acc_input_valid  = input_valid;
    assign acc.acc_output_ready = output_ready;
    assign acc.acc_funct        = funct;

    for (genvar g = 0; g < NUM_CFG_REGS; g++) begin : g_cfg
        assign acc.acc_cfg[g*W +: W] = cfg_q[g];
    end
endmodule
